// File: rtl/fifo_pin_master_if.sv
// rtl/fifo_pin_master_if.sv - push/pop handshake bundle between fifo_pin_master and its user
interface fifo_pin_master_if;
  logic [5:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [5:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid
  );

  modport slave (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid
  );
endinterface

// File: rtl/fifo_pin_master.sv
// rtl/fifo_pin_master.sv - pin-level master driving an external registered FIFO device
// Optional occupancy counter output enabled by FIFO_PIN_MASTER_LEVEL_EN.
module fifo_pin_master #(
  parameter int RESET_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  fifo_pin_master_if.master bus,
  input  logic              flush,
  output logic [7:0]        pin_out,
  input  logic [7:0]        pin_in,
`ifdef FIFO_PIN_MASTER_LEVEL_EN
  output logic [6:0]        level,
`endif
  output logic              busy
);
  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_WRITE, ST_POP} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_WRITE, OP_POP} op_t;

  state_t        state;
  state_t        next_state;
  op_t           last_op;
  logic          phase;
  logic [6:0]    pins_hi;
  logic [6:0]    next_pins;
  logic [CW-1:0] rst_cnt;
  logic          samp_ready;
  logic          samp_empty_n;
  logic          samp_pop;
  logic          pend_pop;
  logic          m_valid_r;
  logic [5:0]    m_data_r;
  logic          write_elig;
  logic          pop_grant;
  logic          pop_first;
  logic          s_ready_c;
  logic          write_take;
  logic          pop_take;
  logic          mv_rise;

  // Decisions are only taken in phase B, using the sample registered on entry to it.
  assign write_elig = phase && samp_ready && (state == ST_IDLE || state == ST_POP);
  assign pop_grant  = phase && pend_pop && (state == ST_IDLE || state == ST_WRITE);
  assign pop_first  = pop_grant && (last_op != OP_POP);
  assign s_ready_c  = write_elig && !pop_first && !flush;
  assign write_take = s_ready_c && bus.s_valid;
  assign pop_take   = pop_grant && !flush && !write_take;

  // Head is trusted only after two clean samples, neither taken during a POP cycle.
  assign mv_rise = pin_in[1] && samp_empty_n && !samp_pop && !m_valid_r && !pend_pop &&
                   (state != ST_POP) && (state != ST_RST);

  always_comb begin
    next_state = ST_IDLE;
    if (flush)
      next_state = ST_RST;
    else if (state == ST_RST)
      next_state = (rst_cnt == RST_LAST) ? ST_IDLE : ST_RST;
    else if (write_take)
      next_state = ST_WRITE;
    else if (pop_take)
      next_state = ST_POP;
  end

  always_comb begin
    next_pins = 7'b000_0000;
    case (next_state)
      ST_WRITE: next_pins = {bus.s_data, 1'b1};
      ST_POP:   next_pins = 7'b000_0110;
      ST_IDLE:  next_pins = 7'b000_0010;
      default:  next_pins = 7'b000_0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_RST;
      last_op      <= OP_NONE;
      phase        <= 1'b0;
      pins_hi      <= '0;
      rst_cnt      <= '0;
      samp_ready   <= 1'b0;
      samp_empty_n <= 1'b0;
      samp_pop     <= 1'b0;
      pend_pop     <= 1'b0;
      m_valid_r    <= 1'b0;
      m_data_r     <= '0;
    end else begin
      phase <= ~phase;
      if (m_valid_r && bus.m_ready) begin
        m_valid_r <= 1'b0;
        pend_pop  <= 1'b1;
      end
      if (!phase) begin
        samp_ready   <= pin_in[0];
        samp_empty_n <= pin_in[1] && (state != ST_RST);
        samp_pop     <= (state == ST_POP);
        if (mv_rise) begin
          m_valid_r <= 1'b1;
          m_data_r  <= pin_in[7:2];
        end
      end else begin
        state   <= next_state;
        pins_hi <= next_pins;
        if (next_state != ST_RST || flush || state != ST_RST)
          rst_cnt <= '0;
        else
          rst_cnt <= rst_cnt + 1'b1;
        case (next_state)
          ST_WRITE: last_op <= OP_WRITE;
          ST_POP:   last_op <= OP_POP;
          ST_RST:   last_op <= OP_NONE;
          default:  last_op <= last_op;
        endcase
        if (pop_take)
          pend_pop <= 1'b0;
        if (flush) begin
          pend_pop  <= 1'b0;
          m_valid_r <= 1'b0;
        end
      end
    end
  end

`ifdef FIFO_PIN_MASTER_LEVEL_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      level <= '0;
    else if (state == ST_RST || (phase && flush))
      level <= '0;
    else if (phase && next_state == ST_WRITE && level != 7'd127)
      level <= level + 7'd1;
    else if (phase && next_state == ST_POP && level != 7'd0)
      level <= level - 7'd1;
  end
`endif

  assign pin_out     = {pins_hi, phase};
  assign busy        = (state == ST_RST);
  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_r;
  assign bus.m_data  = m_data_r;
endmodule

// File: tb/tb_fifo_pin_master.sv
// tb/tb_fifo_pin_master.sv - directed self-checking bench for fifo_pin_master with a device model
module tb_fifo_pin_master;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] pin_out;
  logic [7:0] pin_in;
  logic       busy;
`ifdef FIFO_PIN_MASTER_LEVEL_EN
  logic [6:0] level;
`endif

  fifo_pin_master_if bus ();

  fifo_pin_master #(.RESET_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .flush   (flush),
    .pin_out (pin_out),
    .pin_in  (pin_in),
`ifdef FIFO_PIN_MASTER_LEVEL_EN
    .level   (level),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Device model: acts on entry to phase B, updates its pins just after the edge.
  logic [5:0] mem [0:31];
  int   dcnt = 0;
  logic dev_ready = 1'b1;
  int   cyc = 0;
  int   n_write = 0;
  int   n_pop = 0;
  int   n_rst = 0;
  int   b2b = 0;
  int   last_kind = 0;
  int   last_pop_cyc = 0;

  assign pin_in = {mem[0], (dcnt != 0), (dev_ready && (dcnt < 32))};

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 6'h00;
  end

  always @(posedge clk) begin
    int kind;
    cyc = cyc + 1;
    #1;
    if (reset_n && pin_out[0]) begin
      kind = 0;
      if (pin_out[1]) begin
        if (dcnt < 32) begin
          mem[dcnt] = pin_out[7:2];
          dcnt = dcnt + 1;
        end
        n_write = n_write + 1;
        kind = 1;
      end else if (!pin_out[2]) begin
        dcnt = 0;
        mem[0] = 6'h00;
        n_rst = n_rst + 1;
      end else if (pin_out[3]) begin
        for (int i = 0; i < 31; i++) mem[i] = mem[i+1];
        mem[31] = 6'h00;
        if (dcnt > 0) dcnt = dcnt - 1;
        n_pop = n_pop + 1;
        last_pop_cyc = cyc;
        kind = 2;
      end
      if (kind != 0 && kind == last_kind) b2b = b2b + 1;
      last_kind = kind;
    end
  end

  task automatic apply_reset;
    bit ok;
    reset_n = 1'b0;
    flush = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ok = 0;
    for (int t = 0; t < 30 && !ok; t++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_release busy=%0b required=0", busy);
    end
  endtask

  task automatic test_reset;
    int held;
    reset_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = 6'h00;
    bus.m_ready = 1'b0;
    dev_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (pin_out !== 8'h00) begin failures++; $display("FAIL rst_pin_out got=%h req=00", pin_out); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b req=1", busy); end
    checks++;
    if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b req=0", bus.s_ready); end
    checks++;
    if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b req=0", bus.m_valid); end
    checks++;
    if (bus.m_data !== 6'h00) begin failures++; $display("FAIL rst_m_data got=%h req=00", bus.m_data); end
    reset_n = 1'b1;
    held = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (pin_out[2:1] === 2'b00 && busy === 1'b1 && bus.s_ready === 1'b0 && bus.m_valid === 1'b0)
        held++;
    end
    checks++;
    if (held !== 7) begin failures++; $display("FAIL rst_hold cycles_in_rst=%0d req=7", held); end
    @(negedge clk);
    checks++;
    if (pin_out[2:1] !== 2'b10) begin failures++; $display("FAIL rst_exit_pins got=%b req=10", pin_out[2:1]); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_exit_busy got=%b req=0", busy); end
  endtask

  task automatic test_write;
    int  w0;
    bit  got;
    apply_reset();
    dev_ready = 1'b1;
    w0 = n_write;
    bus.s_data = 6'h15;
    bus.s_valid = 1'b1;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.s_ready) got = 1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL write_s_ready got=0 req=1"); end
    @(posedge clk);
    #2;
    bus.s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pin_out !== 8'h56) begin failures++; $display("FAIL write_pins got=%h req=56", pin_out); end
    @(negedge clk);
    checks++;
    if (pin_out[0] !== 1'b1 || bus.s_ready !== 1'b0) begin
      failures++; $display("FAIL write_no_ready phase=%b s_ready=%b req=1,0", pin_out[0], bus.s_ready);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (n_write - w0 !== 1) begin failures++; $display("FAIL write_count got=%0d req=1", n_write - w0); end
    checks++;
    if (dcnt !== 1 || mem[0] !== 6'h15) begin
      failures++; $display("FAIL write_data cnt=%0d head=%h req=1,15", dcnt, mem[0]);
    end
`ifdef FIFO_PIN_MASTER_LEVEL_EN
    checks++;
    if (level !== 7'd1) begin failures++; $display("FAIL write_level got=%0d req=1", level); end
`endif
  endtask

  task automatic test_pop;
    int  p0;
    bit  got;
    apply_reset();
    @(posedge clk);
    #2;
    mem[0] = 6'h2A;
    mem[1] = 6'h07;
    dcnt = 2;
    p0 = n_pop;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.m_valid) got = 1;
    end
    checks++;
    if (!got || bus.m_data !== 6'h2A) begin
      failures++; $display("FAIL pop_first valid=%b data=%h req=1,2a", got, bus.m_data);
    end
    bus.m_ready = 1'b1;
    @(posedge clk);
    #2;
    bus.m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL pop_drop got=%b req=0", bus.m_valid); end
    got = 0;
    for (int t = 0; t < 30 && !got; t++) begin
      @(negedge clk);
      if (bus.m_valid) got = 1;
    end
    checks++;
    if (!got || bus.m_data !== 6'h07) begin
      failures++; $display("FAIL pop_second valid=%b data=%h req=1,07", got, bus.m_data);
    end
    checks++;
    if (n_pop - p0 !== 1) begin failures++; $display("FAIL pop_count got=%0d req=1", n_pop - p0); end
    checks++;
    if (cyc - last_pop_cyc < 4) begin
      failures++; $display("FAIL pop_gap clk_after_pop=%0d req>=4", cyc - last_pop_cyc);
    end
    bus.m_ready = 1'b1;
    @(posedge clk);
    #2;
    bus.m_ready = 1'b0;
    got = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.m_valid) got = 1;
    end
    checks++;
    if (got !== 1'b0 || dcnt !== 0) begin
      failures++; $display("FAIL pop_empty valid_seen=%b cnt=%0d req=0,0", got, dcnt);
    end
  endtask

  task automatic test_back_to_back;
    int w0;
    int p0;
    int b0;
    int nseen;
    int bad;
    logic [5:0] exp;
    apply_reset();
    @(posedge clk);
    #2;
    mem[0] = 6'h01;
    mem[1] = 6'h02;
    mem[2] = 6'h03;
    dcnt = 3;
    w0 = n_write;
    p0 = n_pop;
    b0 = b2b;
    nseen = 0;
    bad = 0;
    bus.s_data = 6'h3C;
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    repeat (64) begin
      @(negedge clk);
      if (bus.m_valid) begin
        exp = (nseen < 3) ? 6'(nseen + 1) : 6'h3C;
        if (bus.m_data !== exp) bad++;
        nseen++;
      end
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    checks++;
    if (b2b - b0 !== 0) begin failures++; $display("FAIL alt_back_to_back got=%0d req=0", b2b - b0); end
    checks++;
    if (n_write - w0 < 4) begin failures++; $display("FAIL alt_writes got=%0d req>=4", n_write - w0); end
    checks++;
    if (n_pop - p0 < 3) begin failures++; $display("FAIL alt_pops got=%0d req>=3", n_pop - p0); end
    checks++;
    if (bad !== 0 || nseen < 3) begin
      failures++; $display("FAIL alt_data_order bad=%0d words=%0d req=0,>=3", bad, nseen);
    end
  endtask

  task automatic test_not_ready;
    int w0;
    int seen;
    bit got;
    dev_ready = 1'b0;
    apply_reset();
    w0 = n_write;
    bus.s_data = 6'h2D;
    bus.s_valid = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.s_ready) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL nr_s_ready high_cycles=%0d req=0", seen); end
    checks++;
    if (n_write - w0 !== 0) begin failures++; $display("FAIL nr_writes got=%0d req=0", n_write - w0); end
    dev_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (bus.s_ready) got = 1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL nr_resume s_ready=0 req=1"); end
    @(posedge clk);
    #2;
    bus.s_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (n_write - w0 !== 1 || mem[0] !== 6'h2D) begin
      failures++; $display("FAIL nr_write writes=%0d head=%h req=1,2d", n_write - w0, mem[0]);
    end
  endtask

  task automatic test_flush;
    int p0;
    int r0;
    bit got;
    bit mv;
    apply_reset();
    @(posedge clk);
    #2;
    mem[0] = 6'h11;
    dcnt = 1;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.m_valid) got = 1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL flush_setup m_valid=0 req=1"); end
    bus.m_ready = 1'b1;
    @(posedge clk);
    #2;
    bus.m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    p0 = n_pop;
    r0 = n_rst;
    flush = 1'b1;
    @(posedge clk);
    #2;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy got=%b req=1", busy); end
    mv = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.m_valid) mv = 1;
    end
    checks++;
    if (n_pop - p0 !== 0) begin failures++; $display("FAIL flush_no_pop got=%0d req=0", n_pop - p0); end
    checks++;
    if (n_rst - r0 !== 4) begin failures++; $display("FAIL flush_rst_len got=%0d req=4", n_rst - r0); end
    checks++;
    if (mv !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL flush_after valid_seen=%b busy=%b req=0,0", mv, busy);
    end
`ifdef FIFO_PIN_MASTER_LEVEL_EN
    checks++;
    if (level !== 7'd0) begin failures++; $display("FAIL flush_level got=%0d req=0", level); end
`endif
    @(posedge clk);
    #2;
    mem[0] = 6'h22;
    dcnt = 1;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.m_valid) got = 1;
    end
    flush = 1'b1;
    @(posedge clk);
    #2;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (!got || bus.m_valid !== 1'b0) begin
      failures++; $display("FAIL flush_valid_drop seen=%b m_valid=%b req=1,0", got, bus.m_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_pop();
    test_back_to_back();
    test_not_ready();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_pin_master.md
FIFO_PIN_MASTER -- requirements
Module: fifo_pin_master

Interface
REQ-001 Parameter RESET_CYCLES, default 4: number of device cycles the device reset is held.
REQ-002 clk  input  1  system clock; the single clock of the block.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 s_data  input  6  word to push into the device.
REQ-005 s_valid  input  1  s_data valid.
REQ-006 s_ready  output  1  push accepted this clk cycle when s_valid is also high.
REQ-007 m_data  output  6  head word read from the device.
REQ-008 m_valid  output  1  m_data valid.
REQ-009 m_ready  input  1  consumer accepts m_data; triggers a pop.
REQ-010 flush  input  1  re-runs the device reset sequence.
REQ-011 pin_out  output  8  device pins: [0] device clock, [1] mode (1=write), [7:2] write data; with mode=0: [2] reset_n, [3] pop, [7:4] peek (driven 0).
REQ-012 pin_in  input  8  device pins: [0] ready, [1] empty_n, [7:2] registered head data.
REQ-013 busy  output  1  high while in RST.

Function
REQ-014 Device cycle = 2 clk cycles: phase A with pin_out[0]=0, then phase B with pin_out[0]=1; the device samples on entry to phase B.
REQ-015 pin_out[7:1] changes only on the clk edge entering phase A.
REQ-016 pin_in is registered on the clk edge leaving phase A; this is "the sample".
REQ-017 States: RST, IDLE, WRITE, POP; each state lasts exactly one device cycle; the next state is chosen in phase B.
REQ-018 RST drives mode=0, pin_out[2]=0; the block leaves RST to IDLE after RESET_CYCLES device cycles.
REQ-019 IDLE drives mode=0, pin_out[2]=1, pop=0, peek=0.
REQ-020 WRITE drives mode=1, pin_out[7:2]=the accepted s_data word.
REQ-021 POP drives mode=0, pin_out[2]=1, pin_out[3]=1, peek=0.
REQ-022 s_ready is high only during the phase-B clk cycle, and only when the state is not RST, not WRITE, the latest sampled ready=1, and no pop wins arbitration; s_valid&s_ready selects WRITE next.
REQ-023 m_valid rises when empty_n=1 in two consecutive samples and no POP occurred in the two preceding device cycles; m_data is the sampled pin_in[7:2].
REQ-024 m_valid and m_data hold until m_valid&m_ready; then m_valid drops the next clk cycle and a pop is pending.
REQ-025 A pending pop is issued as POP at the next phase-B decision, unless the previous state was POP.
REQ-026 If a pending pop and s_valid are both grantable, the operation not taken in the previous non-IDLE state wins; a pop wins if there is no history.
REQ-027 flush high in phase B cancels any pending pop and drops m_valid; RST is next for RESET_CYCLES device cycles; a write in progress completes.
REQ-028 s_ready=0 and m_valid=0 throughout RST.

Reset
REQ-029 On reset_n low, immediately and asynchronously: state=RST, phase=A, pin_out=8'h00, s_ready=0, m_valid=0, m_data=0, busy=1, pending pop cleared, RST counter=0, samples cleared to 0.
REQ-030 After reset_n rises, the full RST sequence of REQ-018 runs before any write or pop.

Configuration
REQ-031 Macro FIFO_PIN_MASTER_LEVEL_EN: when defined, add output level[6:0].
REQ-032 level is +1 per WRITE, -1 per POP, unchanged if both or neither, 0 on reset and during RST, saturating at 0 and 127.
REQ-033 Without the macro, the level port and logic are absent; all other behaviour is identical.

Verification
REQ-034 Reset release, RESET_CYCLES=4 -> pin_out[2:1]=00 for 8 clk cycles, then IDLE with pin_out[2]=1, busy=0.
REQ-035 Push 0x15 with device model ready=1 -> exactly one WRITE device cycle with pin_out[7:1]=0x2B; s_ready is not high in the following phase B.
REQ-036 Device model holds 0x2A, 0x07 -> m_data=0x2A, then after a pop, m_data=0x07; each m_valid appears ≥2 device cycles after the previous POP.
REQ-037 s_valid held and m_ready held with a non-full, non-empty model -> POP and WRITE alternate; no back-to-back WRITE or POP.
REQ-038 Sampled ready=0 -> s_ready stays 0 and no WRITE occurs; when ready returns to 1, writes resume.
REQ-039 flush while m_valid=1 and a pop is pending -> m_valid drops, no POP occurs, RST runs for 4 device cycles, and level=0 when FIFO_PIN_MASTER_LEVEL_EN is defined.
